// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl
//   Brings a PS/2 mouse up after power-on. It sends Reset (FF), checks the
//   ACK (FA), BAT-pass (AA) and device ID (00) replies, then sends Enable
//   Data Reporting (F4). STREAM goes high once F4 is ACKed. Any bad byte or
//   timeout restarts the whole sequence. After MAX_RETRIES restarts, FAIL
//   latches high.
//
//   Build option SAMPLE_RATE_CFG_EN inserts "F3 <SAMPLE_RATE>" between FF
//   and F4. Each of those bytes needs its own FA.
//
// Ports
//   CLK, RST          clock, async active-high reset
//   start             pulse; (re)starts the sequence when not busy
//   tx_idle, tx_done  transmitter ready / byte-sent pulse
//   tx_write, datain  one-cycle write strobe and command byte
//   rx_valid, rx_data received byte strobe and data
//   STREAM, FAIL      mouse reporting / sticky failure
//   busy, retry_cnt   sequence in progress / restarts used so far
module ps2_mouse_init_ctrl #(
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter int          MAX_RETRIES    = 3,
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       tx_idle,
  input  logic       tx_done,
  output logic       tx_write,
  output logic [7:0] datain,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       STREAM,
  output logic       FAIL,
  output logic       busy,
  output logic [1:0] retry_cnt
);

  localparam int             TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
  // retry_cnt is 2 bits, so the budget is clamped to what it can hold
  localparam logic [1:0]     MAX_R  = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);
`ifdef SAMPLE_RATE_CFG_EN
  localparam logic [1:0]     LAST_STEP = 2'd3;
`else
  localparam logic [1:0]     LAST_STEP = 2'd1;
`endif

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAMING, ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [1:0]      retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            stream_d, fail_d, tx_write_d;
  logic [7:0]      datain_d;
  logic            fail_ev, timeout;

  function automatic logic [7:0] cmd_byte(input logic [1:0] s);
`ifdef SAMPLE_RATE_CFG_EN
    case (s)
      2'd0:    return 8'hFF;
      2'd1:    return 8'hF3;
      2'd2:    return SAMPLE_RATE;
      default: return 8'hF4;
    endcase
`else
    return (s == 2'd0) ? 8'hFF : 8'hF4;
`endif
  endfunction

  assign timeout = (timer_q == T_LAST);
  assign busy    = !(state_q inside {IDLE, STREAMING, ERROR});

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    retry_d    = retry_cnt;
    stream_d   = STREAM;
    fail_d     = FAIL;
    tx_write_d = 1'b0;
    datain_d   = datain;
    fail_ev    = 1'b0;
    timer_d    = '0;

    case (state_q)
      IDLE, STREAMING, ERROR: begin
        // rx bytes in STREAMING belong to the packet decoder
        if (start) begin
          stream_d = 1'b0;
          fail_d   = 1'b0;
          retry_d  = 2'd0;
          step_d   = 2'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_idle) begin
          datain_d   = cmd_byte(step_q);
          tx_write_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        timer_d = timer_q + 1'b1;
        if (tx_done)      state_d = WAIT_ACK;
        else if (timeout) fail_ev = 1'b1;
      end
      WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        // a byte arriving on the timeout cycle takes priority
        if (rx_valid) begin
          case (rx_data)
            8'hFA: begin
              if (step_q == 2'd0) state_d = WAIT_BAT;
              else if (step_q == LAST_STEP) begin
                state_d  = STREAMING;
                stream_d = 1'b1;
              end else begin
                step_d  = step_q + 2'd1;
                state_d = SEND;
              end
            end
            8'hFE:   state_d = SEND;   // resend same byte, not a retry
            default: fail_ev = 1'b1;
          endcase
        end else if (timeout) fail_ev = 1'b1;
      end
      WAIT_BAT: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          if (rx_data == 8'hAA) state_d = WAIT_ID;
          else                  fail_ev = 1'b1;
        end else if (timeout) fail_ev = 1'b1;
      end
      WAIT_ID: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          if (rx_data == 8'h00) begin
            step_d  = step_q + 2'd1;
            state_d = SEND;
          end else fail_ev = 1'b1;
        end else if (timeout) fail_ev = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fail_ev) begin
      if (retry_cnt < MAX_R) begin
        retry_d = retry_cnt + 2'd1;
        step_d  = 2'd0;
        state_d = SEND;
      end else begin
        state_d = ERROR;
        fail_d  = 1'b1;
      end
    end

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      retry_cnt <= 2'd0;
      timer_q   <= '0;
      STREAM    <= 1'b0;
      FAIL      <= 1'b0;
      tx_write  <= 1'b0;
      datain    <= 8'h00;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      retry_cnt <= retry_d;
      timer_q   <= timer_d;
      STREAM    <= stream_d;
      FAIL      <= fail_d;
      tx_write  <= tx_write_d;
      datain    <= datain_d;
    end
  end

endmodule
